// File: rtl/line_mem_responder_if.sv
// Cache <-> main-memory line transfer bus. The cache is the master (initiator) and the
// memory responder is the slave.
interface line_mem_responder_if;
   logic        mem_rd_req;
   logic        mem_wr_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_word;
   logic        mem_wr_valid;
   logic        mem_wr_ready;
   logic [31:0] mem_rd_word;
   logic        mem_rd_valid;
   logic        mem_done;
   logic        mem_busy;

   modport master (
      output mem_rd_req, mem_wr_req, mem_addr, mem_wr_word, mem_wr_valid,
      input  mem_wr_ready, mem_rd_word, mem_rd_valid, mem_done, mem_busy
   );

   modport slave (
      input  mem_rd_req, mem_wr_req, mem_addr, mem_wr_word, mem_wr_valid,
      output mem_wr_ready, mem_rd_word, mem_rd_valid, mem_done, mem_busy
   );
endinterface

// File: rtl/line_mem_responder.sv
// Main-memory responder for cache line refills and writebacks. It serves one line at a
// time after a fixed access latency and moves one 32-bit word per beat.
module line_mem_responder #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int MEM_ADDR_LEN  = 12,
   parameter int LATENCY       = 50
) (
   input  logic                       clk,
   input  logic                       rst,
   line_mem_responder_if.slave        bus,
   output logic [31:0]                rd_line_cnt,
   output logic [31:0]                wr_line_cnt
);

   localparam int LINE_W    = MEM_ADDR_LEN - LINE_ADDR_LEN;
   localparam int MEM_WORDS = 2 ** MEM_ADDR_LEN;
   localparam int LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [LINE_ADDR_LEN-1:0] BEAT_LAST = {LINE_ADDR_LEN{1'b1}};

   if (LATENCY < 1) begin : g_latency_check
      $error("line_mem_responder: LATENCY must be at least 1");
   end

   typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, DONE} state_t;

   state_t                    state, state_nxt;
   logic [LINE_ADDR_LEN-1:0]  beat, beat_nxt;
   logic [LAT_W-1:0]          lat_cnt, lat_nxt;
   logic [LINE_W-1:0]         line, line_nxt;
   logic                      op_wr, op_wr_nxt;
   logic                      mem_we;
   logic [MEM_ADDR_LEN-1:0]   rd_idx;
   logic [MEM_ADDR_LEN-1:0]   wr_idx;

   logic [31:0]               rd_word;
   logic                      rd_valid;
   logic                      wr_ready;
   logic                      done;
   logic                      busy;
   logic                      unused_addr_bits;

   // Backing storage has no reset so that line contents survive a reset of the FSM.
   logic [31:0]               mem [MEM_WORDS];

   assign unused_addr_bits = ^{bus.mem_addr[31:MEM_ADDR_LEN+2], bus.mem_addr[LINE_ADDR_LEN+1:0]};

   // Read data is fetched with the next-cycle index so the registered word lines up with rd_valid.
   assign rd_idx = {line_nxt, beat_nxt};
   assign wr_idx = {line, beat};

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      lat_nxt   = lat_cnt;
      line_nxt  = line;
      op_wr_nxt = op_wr;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.mem_wr_req || bus.mem_rd_req) begin
               line_nxt  = bus.mem_addr[MEM_ADDR_LEN+1 -: LINE_W];
               op_wr_nxt = bus.mem_wr_req;
               lat_nxt   = LAT_W'(LATENCY - 1);
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               beat_nxt  = '0;
               state_nxt = op_wr ? WBURST : RBURST;
            end else begin
               lat_nxt = lat_cnt - 1'b1;
            end
         end
         RBURST: begin
            if (beat == BEAT_LAST) state_nxt = DONE;
            else                   beat_nxt  = beat + 1'b1;
         end
         WBURST: begin
            if (bus.mem_wr_valid) begin
               mem_we = 1'b1;
               if (beat == BEAT_LAST) state_nxt = DONE;
               else                   beat_nxt  = beat + 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         beat        <= '0;
         lat_cnt     <= '0;
         line        <= '0;
         op_wr       <= 1'b0;
         rd_word     <= '0;
         rd_valid    <= 1'b0;
         wr_ready    <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         rd_line_cnt <= '0;
         wr_line_cnt <= '0;
      end else begin
         state    <= state_nxt;
         beat     <= beat_nxt;
         lat_cnt  <= lat_nxt;
         line     <= line_nxt;
         op_wr    <= op_wr_nxt;
         rd_valid <= (state_nxt == RBURST);
         rd_word  <= (state_nxt == RBURST) ? mem[rd_idx] : '0;
         wr_ready <= (state_nxt == WBURST);
         done     <= (state_nxt == DONE);
         busy     <= (state_nxt != IDLE);
         if (state_nxt == DONE) begin
            if (op_wr) wr_line_cnt <= wr_line_cnt + 1'b1;
            else       rd_line_cnt <= rd_line_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst && mem_we) mem[wr_idx] <= bus.mem_wr_word;
   end

   assign bus.mem_rd_word  = rd_word;
   assign bus.mem_rd_valid = rd_valid;
   assign bus.mem_wr_ready = wr_ready;
   assign bus.mem_done     = done;
   assign bus.mem_busy     = busy;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed self-checking bench for line_mem_responder: refill timing, writebacks with
// stalls, read/write arbitration, reset mid-burst and address aliasing.
module tb_line_mem_responder;

   localparam int LATENCY = 50;
   localparam logic [31:0] JUNK_ADDR = 32'hFFFF_FFE0;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rd_line_cnt;
   logic [31:0] wr_line_cnt;
   int          checks = 0;
   int          errors = 0;

   line_mem_responder_if bus();

   line_mem_responder #(
      .LINE_ADDR_LEN (3),
      .MEM_ADDR_LEN  (12),
      .LATENCY       (LATENCY)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .rd_line_cnt (rd_line_cnt),
      .wr_line_cnt (wr_line_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr);
      bus.mem_rd_req = rd;
      bus.mem_wr_req = wr;
      bus.mem_addr   = addr;
   endtask

   task automatic applyReset(input int cycles);
      rst = 1'b0;
      repeat (cycles) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Cycle k counts from the acceptance edge; words before split come from newBase, the rest from oldBase.
   task automatic readLine(input logic [31:0] addr, input logic [31:0] newBase,
                           input logic [31:0] oldBase, input int split);
      int          k;
      int          firstValid;
      int          doneK;
      int          beats;
      logic [31:0] expWord;
      k = -1; firstValid = -1; doneK = -1; beats = 0;
      applyStimulus(1'b1, bus.mem_wr_req, addr);
      for (int g = 0; g < 200 && doneK < 0; g++) begin
         @(negedge clk);
         if (k >= 0) k++;
         else if (bus.mem_busy) begin
            k = 0;
            bus.mem_addr = JUNK_ADDR;
         end
         if (k >= 0 && bus.mem_rd_valid) begin
            expWord = (beats < split) ? newBase + 32'(beats) : oldBase + 32'(beats);
            checkOutput($sformatf("rd_word[%0d] addr 0x%0h", beats, addr), bus.mem_rd_word, expWord);
            if (firstValid < 0) firstValid = k;
            beats++;
         end
         if (k >= 0 && bus.mem_done) doneK = k;
      end
      bus.mem_rd_req = 1'b0;
      checkOutput("first_valid_cycle", 32'(firstValid), 32'(LATENCY));
      checkOutput("rd_beat_count", 32'(beats), 32'd8);
      checkOutput("rd_done_cycle", 32'(doneK), 32'(LATENCY + 8));
      @(negedge clk);
      checkOutput("rd_done_pulse_width", 32'(bus.mem_done), 32'd0);
   endtask

   // Drives beats only in cycles where wr_ready is seen; a set stallMask bit idles that burst cycle.
   task automatic writeLine(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] postAddr,
                            input logic [15:0] stallMask, input int abortAfter, input int expBurst);
      int   beat;
      int   burst;
      logic accepted;
      logic doneSeen;
      logic readyDrop;
      beat = 0; burst = 0; accepted = 1'b0; doneSeen = 1'b0; readyDrop = 1'b0;
      applyStimulus(bus.mem_rd_req, 1'b1, addr);
      for (int g = 0; g < 400; g++) begin
         @(negedge clk);
         if (!accepted && bus.mem_busy) begin
            accepted = 1'b1;
            bus.mem_addr = postAddr;
         end
         if (bus.mem_done) begin
            doneSeen = 1'b1;
            break;
         end
         if (beat == abortAfter) break;
         if (bus.mem_wr_ready) begin
            if (burst < 16 && stallMask[burst]) begin
               bus.mem_wr_valid = 1'b0;
            end else begin
               bus.mem_wr_valid = 1'b1;
               bus.mem_wr_word  = base + 32'(beat);
               beat++;
            end
            burst++;
         end else begin
            bus.mem_wr_valid = 1'b0;
            if (burst > 0) readyDrop = 1'b1;
         end
      end
      bus.mem_wr_valid = 1'b0;
      bus.mem_wr_req   = 1'b0;
      if (abortAfter >= 8) begin
         checkOutput($sformatf("wr_done_seen addr 0x%0h", addr), 32'(doneSeen), 32'd1);
         checkOutput("wr_burst_cycles", 32'(burst), 32'(expBurst));
         checkOutput("wr_ready_held", 32'(readyDrop), 32'd0);
         @(negedge clk);
         checkOutput("wr_done_pulse_width", 32'(bus.mem_done), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      bus.mem_wr_word  = 32'h0;
      bus.mem_wr_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(bus.mem_busy), 32'd0);
      checkOutput("reset_done", 32'(bus.mem_done), 32'd0);
      checkOutput("reset_rd_valid", 32'(bus.mem_rd_valid), 32'd0);
      checkOutput("reset_wr_ready", 32'(bus.mem_wr_ready), 32'd0);
      checkOutput("reset_rd_word", bus.mem_rd_word, 32'd0);
      checkOutput("reset_rd_cnt", rd_line_cnt, 32'd0);
      checkOutput("reset_wr_cnt", wr_line_cnt, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      $display("[TB] preload lines 0x0 and 0x20");
      writeLine(32'h0,  32'h100, JUNK_ADDR, 16'h0, 8, 8);
      writeLine(32'h20, 32'h200, JUNK_ADDR, 16'h0, 8, 8);
      checkOutput("preload_wr_cnt", wr_line_cnt, 32'd2);
      applyReset(2);
      checkOutput("post_reset_wr_cnt", wr_line_cnt, 32'd0);

      $display("[TB] test 1: refill timing");
      readLine(32'h0, 32'h100, 32'h100, 8);
      checkOutput("t1_rd_cnt", rd_line_cnt, 32'd1);

      $display("[TB] test 2: writeback and readback");
      writeLine(32'h40, 32'hA0, JUNK_ADDR, 16'h0, 8, 8);
      checkOutput("t2_wr_cnt", wr_line_cnt, 32'd1);
      readLine(32'h40, 32'hA0, 32'hA0, 8);
      checkOutput("t2_rd_cnt", rd_line_cnt, 32'd2);

      $display("[TB] test 3: simultaneous read and write requests");
      applyReset(2);
      bus.mem_rd_req = 1'b1;
      writeLine(32'h60, 32'hB0, 32'h20, 16'h0, 8, 8);
      checkOutput("t3_wr_cnt_after_first", wr_line_cnt, 32'd1);
      checkOutput("t3_rd_cnt_after_first", rd_line_cnt, 32'd0);
      readLine(32'h20, 32'h200, 32'h200, 8);
      checkOutput("t3_rd_cnt", rd_line_cnt, 32'd1);
      checkOutput("t3_wr_cnt", wr_line_cnt, 32'd1);
      readLine(32'h60, 32'hB0, 32'hB0, 8);

      $display("[TB] test 4: writeback with valid stalls");
      writeLine(32'h80, 32'hD0, JUNK_ADDR, 16'h0044, 8, 10);
      checkOutput("t4_wr_cnt", wr_line_cnt, 32'd2);
      readLine(32'h80, 32'hD0, 32'hD0, 8);
      checkOutput("t4_rd_cnt", rd_line_cnt, 32'd3);

      $display("[TB] test 5: reset in the middle of a writeback");
      writeLine(32'h40, 32'hC0, JUNK_ADDR, 16'h0, 4, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t5_done_in_reset", 32'(bus.mem_done), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t5_done_after_reset", 32'(bus.mem_done), 32'd0);
      checkOutput("t5_busy", 32'(bus.mem_busy), 32'd0);
      checkOutput("t5_rd_cnt", rd_line_cnt, 32'd0);
      checkOutput("t5_wr_cnt", wr_line_cnt, 32'd0);
      readLine(32'h40, 32'hC0, 32'hA0, 4);

      $display("[TB] test 6: address aliasing above storage size");
      readLine(32'h4000, 32'h100, 32'h100, 8);
      checkOutput("t6_rd_cnt", rd_line_cnt, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
